// File: rtl/keypad_event_queue_if.sv
// Event handshake between the keypad event queue and its consumer.
//   ev_valid : queue holds at least one press event (master drives)
//   ev_code  : key code of the head event (master drives)
//   ev_ready : consumer takes the head event this cycle (slave drives)
interface keypad_event_queue_if;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_ready;

  modport master (output ev_valid, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_code, output ev_ready);
endinterface

// File: rtl/keypad_event_queue.sv
// Keypad event queue: turns raw 4x4 keypad scanner samples into one clean
// press event per physical press, buffers events in a small FWFT FIFO and
// offers them to the game logic over a valid/ready handshake. Also reports
// the key that is currently qualified as held.
// Ports:
//   clk            system clock, all logic on posedge
//   rst_n          synchronous reset, active low
//   key            scanner code (0..15 key, anything else = no key)
//   keypad_pressed scanner press flag
//   clr_overflow   clears the sticky overflow flag
//   ev             event handshake (master side: ev_valid/ev_code out, ev_ready in)
//   held           a key is currently qualified as held
//   held_code      code of the held key (meaningful while held=1)
//   fifo_count     number of queued events
//   overflow       sticky: a press event was dropped on a full queue
module keypad_event_queue #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int RELEASE_CYCLES  = 24000,
  parameter int DEPTH           = 4,
  parameter int CNT_W           = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4:0]                key,
  input  logic                      keypad_pressed,
  input  logic                      clr_overflow,
  keypad_event_queue_if.master      ev,
  output logic                      held,
  output logic [3:0]                held_code,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] REL_LIM = CNT_W'(RELEASE_CYCLES);
  localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMING, HELD} state_t;

  state_t           state_reg;
  logic [3:0]       cand_reg;
  logic [CNT_W-1:0] deb_cnt_reg;
  logic [CNT_W-1:0] rel_cnt_reg;
  logic             held_reg;
  logic [3:0]       held_code_reg;

  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             overflow_reg;

  logic sample_valid;
  logic deb_done;
  logic rel_done;
  logic qualify;
  logic pop;
  logic do_push;
  logic drop;

  // Codes 16..31 all have bit 4 set, so bit 4 alone separates key from no-key.
  assign sample_valid = keypad_pressed & ~key[4];
  assign deb_done     = (deb_cnt_reg + 1'b1) == DEB_LIM;
  assign rel_done     = (rel_cnt_reg + 1'b1) == REL_LIM;

  // Press qualifies on the very sample that completes debounce, so the push
  // lands on the same edge as the transition into HELD.
  always_comb begin
    qualify = 1'b0;
    if (sample_valid) begin
      case (state_reg)
        IDLE:    qualify = (DEBOUNCE_CYCLES == 1);
        ARMING:  qualify = (key[3:0] == cand_reg) && deb_done;
        default: qualify = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cand_reg      <= '0;
      deb_cnt_reg   <= '0;
      rel_cnt_reg   <= '0;
      held_reg      <= 1'b0;
      held_code_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sample_valid) begin
            cand_reg    <= key[3:0];
            deb_cnt_reg <= CNT_W'(1);
            rel_cnt_reg <= '0;
            if (qualify) begin
              state_reg     <= HELD;
              held_reg      <= 1'b1;
              held_code_reg <= key[3:0];
            end else begin
              state_reg <= ARMING;
            end
          end
        end
        ARMING: begin
          if (sample_valid) begin
            rel_cnt_reg <= '0;
            if (key[3:0] != cand_reg) begin
              // A different key restarts debounce on the new code.
              cand_reg    <= key[3:0];
              deb_cnt_reg <= CNT_W'(1);
            end else begin
              if (deb_cnt_reg != DEB_LIM) deb_cnt_reg <= deb_cnt_reg + 1'b1;
              if (qualify) begin
                state_reg     <= HELD;
                held_reg      <= 1'b1;
                held_code_reg <= cand_reg;
              end
            end
          end else begin
            // Short dropouts keep the debounce progress.
            if (rel_cnt_reg != REL_LIM) rel_cnt_reg <= rel_cnt_reg + 1'b1;
            if (rel_done) begin
              state_reg   <= IDLE;
              deb_cnt_reg <= '0;
              rel_cnt_reg <= '0;
            end
          end
        end
        HELD: begin
          if (sample_valid) begin
            rel_cnt_reg <= '0;
          end else begin
            if (rel_cnt_reg != REL_LIM) rel_cnt_reg <= rel_cnt_reg + 1'b1;
            if (rel_done) begin
              state_reg   <= IDLE;
              held_reg    <= 1'b0;
              deb_cnt_reg <= '0;
              rel_cnt_reg <= '0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A pop frees a slot on the same edge, so a push into a full queue that is
  // being drained is accepted rather than dropped.
  assign pop     = (count_reg != '0) & ev.ev_ready;
  assign do_push = qualify & ((count_reg != FULL) | pop);
  assign drop    = qualify & (count_reg == FULL) & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_reg] <= key[3:0];
        wr_ptr_reg      <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop)              overflow_reg <= 1'b1;
      else if (clr_overflow) overflow_reg <= 1'b0;
    end
  end

  assign ev.ev_valid = (count_reg != '0);
  assign ev.ev_code  = mem[rd_ptr_reg];
  assign held        = held_reg;
  assign held_code   = held_code_reg;
  assign fifo_count  = count_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Bench for keypad_event_queue with DEBOUNCE_CYCLES=3, RELEASE_CYCLES=4,
// DEPTH=4. A behavioural model (press-qualification rules plus a queue) runs
// on every posedge; one compare process checks the DUT against it on every
// negedge. Directed scenarios add hand-computed literal expectations.
module tb_keypad_event_queue;
  localparam int DEB = 3;
  localparam int REL = 4;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] key;
  logic       kp;
  logic       rdy;
  logic       clr;
  logic       held;
  logic [3:0] held_code;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  keypad_event_queue_if ev_if ();
  assign ev_if.ev_ready = rdy;

  keypad_event_queue #(
    .DEBOUNCE_CYCLES(DEB),
    .RELEASE_CYCLES (REL),
    .DEPTH          (DEP),
    .CNT_W          (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key           (key),
    .keypad_pressed(kp),
    .clr_overflow  (clr),
    .ev            (ev_if.master),
    .held          (held),
    .held_code     (held_code),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A press is recognised once DEB valid samples of one code have been seen
  // while not held, with no run of REL invalid samples in between; a new code
  // starts the count over. A held key is released after REL invalid samples.
  logic [3:0] m_q[$];
  bit         m_held, m_arming, m_ovf;
  logic [3:0] m_hcode, m_cand;
  int         m_good, m_bad;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_held = 0; m_arming = 0; m_ovf = 0;
      m_hcode = 0; m_cand = 0; m_good = 0; m_bad = 0;
    end else begin
      bit v, push, pop;
      int size_before;
      v = kp && (key <= 5'd15);
      push = 0;
      size_before = m_q.size();
      pop = (size_before != 0) && rdy;
      if (v) begin
        m_bad = 0;
        if (!m_held) begin
          if (m_arming && key[3:0] == m_cand) m_good++;
          else begin m_arming = 1; m_cand = key[3:0]; m_good = 1; end
          if (m_good >= DEB) begin
            push = 1; m_held = 1; m_hcode = m_cand; m_arming = 0;
          end
        end
      end else if (m_held || m_arming) begin
        m_bad++;
        if (m_bad >= REL) begin m_held = 0; m_arming = 0; m_bad = 0; m_good = 0; end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (size_before < DEP || pop) m_q.push_back(m_cand);
        else m_ovf = 1;
      end else if (clr) m_ovf = 0;
      if (push && !(size_before < DEP || pop)) m_ovf = 1;
      else if (clr && push) m_ovf = m_ovf;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("ev_valid", int'(ev_if.ev_valid), int'(m_q.size() != 0));
      chk("fifo_count", int'(fifo_count), m_q.size());
      chk("held", int'(held), int'(m_held));
      chk("overflow", int'(overflow), int'(m_ovf));
      if (m_q.size() != 0) chk("ev_code", int'(ev_if.ev_code), int'(m_q[0]));
      if (m_held) chk("held_code", int'(held_code), int'(m_hcode));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int k, input bit p, input bit r = 1'b0, input bit c = 1'b0);
    key = 5'(k); kp = p; rdy = r; clr = c;
    @(negedge clk);
  endtask

  task automatic press(input int code);
    repeat (DEB) cyc(code, 1'b1);
    $display("[TB] press code=%0d count=%0d", code, fifo_count);
  endtask

  task automatic release_key();
    repeat (REL) cyc(31, 1'b0);
  endtask

  task automatic pop_expect(input int code);
    chk("pop_valid", int'(ev_if.ev_valid), 1);
    chk("pop_code", int'(ev_if.ev_code), code);
    $display("[TB] pop code=%0d expected=%0d", ev_if.ev_code, code);
    cyc(31, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; key = 5'd31; kp = 1'b0; rdy = 1'b0; clr = 1'b0;
    @(negedge clk);
    started = 1'b1;
    @(negedge clk);
    chk("rst_ev_valid", int'(ev_if.ev_valid), 0);
    chk("rst_ev_code", int'(ev_if.ev_code), 0);
    chk("rst_held", int'(held), 0);
    chk("rst_held_code", int'(held_code), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;

    // T1: basic press and release; ready while empty is ignored
    cyc(31, 1'b0, 1'b1);
    chk("t1_empty_ready", int'(fifo_count), 0);
    cyc(5, 1'b1); cyc(5, 1'b1);
    chk("t1_not_yet", int'(ev_if.ev_valid), 0);
    cyc(5, 1'b1);
    chk("t1_valid", int'(ev_if.ev_valid), 1);
    chk("t1_code", int'(ev_if.ev_code), 5);
    chk("t1_count", int'(fifo_count), 1);
    chk("t1_held", int'(held), 1);
    chk("t1_held_code", int'(held_code), 5);
    repeat (3) cyc(31, 1'b0);
    chk("t1_held_3inv", int'(held), 1);
    cyc(31, 1'b0);
    chk("t1_released", int'(held), 0);
    pop_expect(5);
    chk("t1_drained", int'(fifo_count), 0);

    // T2: glitch on 7 then stable 9
    cyc(7, 1'b1); cyc(7, 1'b1);
    cyc(9, 1'b1); cyc(9, 1'b1);
    chk("t2_no7", int'(fifo_count), 0);
    cyc(9, 1'b1);
    chk("t2_count", int'(fifo_count), 1);
    chk("t2_code", int'(ev_if.ev_code), 9);
    release_key();
    pop_expect(9);

    // T3: chatter while held
    press(2);
    for (int i = 0; i < 5; i++) begin
      cyc(31, 1'b0); cyc(31, 1'b0); cyc(2, 1'b1); cyc(2, 1'b1);
      chk("t3_held", int'(held), 1);
    end
    chk("t3_one_event", int'(fifo_count), 1);
    release_key();
    pop_expect(2);

    // T4: overflow on fifth press
    for (int c = 0; c < 5; c++) begin press(c); release_key(); end
    chk("t4_count", int'(fifo_count), 4);
    chk("t4_overflow", int'(overflow), 1);
    for (int c = 0; c < 4; c++) pop_expect(c);
    chk("t4_ovf_sticky", int'(overflow), 1);
    cyc(31, 1'b0, 1'b0, 1'b1);
    chk("t4_ovf_clr", int'(overflow), 0);

    // T5: push and pop on the same edge while full
    for (int c = 1; c <= 4; c++) begin press(c); release_key(); end
    cyc(8, 1'b1); cyc(8, 1'b1);
    cyc(8, 1'b1, 1'b1);
    chk("t5_count", int'(fifo_count), 4);
    chk("t5_overflow", int'(overflow), 0);
    release_key();
    pop_expect(2); pop_expect(3); pop_expect(4); pop_expect(8);
    chk("t5_empty", int'(fifo_count), 0);

    // T6: reset mid-arming
    cyc(6, 1'b1); cyc(6, 1'b1);
    rst_n = 1'b0;
    cyc(6, 1'b1);
    rst_n = 1'b1;
    chk("t6_valid", int'(ev_if.ev_valid), 0);
    chk("t6_code", int'(ev_if.ev_code), 0);
    chk("t6_held", int'(held), 0);
    chk("t6_count", int'(fifo_count), 0);
    chk("t6_overflow", int'(overflow), 0);
    cyc(6, 1'b1); cyc(6, 1'b1);
    chk("t6_not_yet", int'(fifo_count), 0);
    cyc(6, 1'b1);
    chk("t6_count_after", int'(fifo_count), 1);
    chk("t6_code_after", int'(ev_if.ev_code), 6);
    chk("t6_held_after", int'(held), 1);
    release_key();
    pop_expect(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
